axis_tlast_timeout: RTL and testbench
=====================================

Name: axis_tlast_timeout

Overview:
- Sits directly downstream of the FT245 sync-to-AXIS converter, on its master AXIS stream, in the ft245_dclk domain.
- That stream carries bytes with tkeep but no tlast. This block adds packet framing so DMA and packet consumers can close frames.
- It holds one beat and asserts tlast on that beat when any of these occurs: the maximum packet length is reached, the beat is partial (tkeep not all ones), or the input has been idle for a programmed number of cycles.

Parameters:
- bus_width, 1, number of data bytes per beat. tdata is bus_width*8 bits.
- max_len, 512, maximum number of beats per packet. Must be at least 1.
- timeout, 256, number of idle cycles before the held beat is closed with tlast. 0 disables the timeout.

Ports:
- aclk  input  1  clock. Connected to ft245_dclk.
- arstn  input  1  reset, asynchronous assert, active-low.
- s_axis_tdata  input  bus_width*8  input data.
- s_axis_tkeep  input  bus_width  input byte enables.
- s_axis_tvalid  input  1  input valid.
- s_axis_tready  output  1  input ready.
- m_axis_tdata  output  bus_width*8  output data, taken from the hold register.
- m_axis_tkeep  output  bus_width  output byte enables, taken from the hold register.
- m_axis_tvalid  output  1  output valid.
- m_axis_tready  input  1  output ready.
- m_axis_tlast  output  1  end of packet.

Behaviour:
- Clock and reset: one clock, aclk. Reset arstn is asynchronous and active-low. No other clocks.
- Reset values: all registers 0. m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, s_axis_tready=0 while arstn=0. s_axis_tready first rises on the first aclk edge after arstn deasserts (registered ready-enable flag).
- State is encoded by two flags, r_valid and r_flush:
  - EMPTY: r_valid=0.
  - HOLD: r_valid=1, r_flush=0.
  - FLUSH: r_valid=1, r_flush=1.
- Outputs:
  - m_axis_tlast = r_flush.
  - m_axis_tvalid = r_valid & (r_flush | s_axis_tvalid). A HOLD beat is released only when a successor beat is present, so tlast is always known at the time of release.
  - s_axis_tready = ready_en & (~r_valid | m_axis_tready).
- Load: occurs on s_axis_tvalid & s_axis_tready. The input beat enters the hold register on the same edge that the old beat transfers out, if one does.
- Transfer out: occurs on m_axis_tvalid & m_axis_tready. If no load happens on that edge, the block goes to EMPTY.
- Packet counter pkt_cnt (width clog2(max_len+1)) counts beats loaded in the current packet.
  - On load: if the previous beat closed a packet (FLUSH transfer on the same edge, or block was EMPTY after a tlast), the new beat gets index 1. Otherwise it gets pkt_cnt+1.
- On load, r_flush is set to (new index == max_len) | (s_axis_tkeep != all ones).
  - A beat loaded as FLUSH is released without waiting for a successor.
- Idle counter:
  - Cleared on load.
  - Increments each cycle in HOLD with s_axis_tvalid=0.
  - When it would reach timeout, r_flush is set to 1. The held beat therefore shows tlast exactly timeout cycles after its load edge if no input arrives.
  - Cycles where s_axis_tvalid=1 but m_axis_tready=0 are back-pressure, not idle, and do not count.
  - timeout=0: the counter is never used.
- Simultaneous events:
  - Timeout expiry on the same cycle a new beat arrives: the arrival wins. The old beat is released with tlast=0 and the counter is cleared.
- FLUSH with m_axis_tready=0: tvalid, tdata, tkeep and tlast stay stable until accepted. Input stalls.
- max_len=1: every beat carries tlast.
- Reset mid-packet: the held beat is discarded. pkt_cnt and the idle counter clear. The next beat after reset has index 1.
- Throughput: one beat per cycle in steady streaming. Latency input to output is one beat (the hold register). No combinational path from s_axis_tdata to m_axis_tdata.

Decomposition:
- No shared package. Widths derive from parameters locally, and the all-ones tkeep constant is computed from bus_width.
- No sub-module is needed. The hold register, counters and flags form one always block plus continuous assigns.
- Optionally, place this block in a wrapper alongside the FT245 converter for top-level use.

Test Plan:
- Continuous stream: 10 beats 0x00..0x09, timeout=8, m_axis_tready=1, then idle.
  - Required: 0x00..0x08 output with tlast=0. 0x09 output with tlast=1 exactly 8 cycles after its load.
- max_len=4, 9 back-to-back beats.
  - Required: tlast on beats 4, 8 and (after timeout) 9. No bubble cycles between beats 1-8.
- bus_width=2, beats with tkeep 0x3, 0x3, 0x1.
  - Required: third beat output immediately with tlast=1, without waiting for timeout. The next beat starts a new packet at index 1.
- Back-pressure: m_axis_tready=0 for 20 cycles with s_axis_tvalid=1 and timeout=8.
  - Required: no tlast asserted, tvalid/tdata stable, s_axis_tready=0 throughout.
- Arrival on the expiry cycle: new beat arrives on the cycle the idle counter would expire.
  - Required: old beat released with tlast=0.
- Reset mid-packet: arstn pulsed low asynchronously while in HOLD.
  - Required: all outputs 0 immediately. s_axis_tready=0 until the first edge after release. The next packet counts from 1.

Source files
------------

// File: rtl/axis_tlast_timeout.sv
// AXI-Stream packet framer for a tlast-less byte stream.
// One beat is held back so that tlast is known when it leaves. tlast is raised
// when the packet reaches max_len beats, when a beat is partial (tkeep not all
// ones), or when the input has been idle for `timeout` cycles while a beat is held.
module axis_tlast_timeout #(
    parameter int bus_width = 1,
    parameter int max_len   = 512,
    parameter int timeout   = 256
) (
    input  logic                   aclk,
    input  logic                   arstn,
    input  logic [bus_width*8-1:0] s_axis_tdata,
    input  logic [bus_width-1:0]   s_axis_tkeep,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [bus_width*8-1:0] m_axis_tdata,
    output logic [bus_width-1:0]   m_axis_tkeep,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast
);

    localparam int DW = bus_width * 8;
    localparam int CW = $clog2(max_len + 1);
    localparam int IW = (timeout > 0) ? $clog2(timeout + 1) : 1;

    localparam bit                 TO_EN    = (timeout != 0);
    localparam logic [bus_width-1:0] KEEP_ALL = '1;
    localparam logic [CW-1:0]      LEN_LIM  = CW'(max_len);
    localparam logic [CW-1:0]      IDX_ONE  = CW'(1);
    // Value of the idle counter on the cycle whose closing edge expires the timer.
    localparam logic [IW-1:0]      IDLE_LIM = IW'((timeout > 0) ? timeout - 1 : 0);

    logic          ready_en;
    logic          r_valid;
    logic          r_flush;
    logic [DW-1:0] r_data;
    logic [bus_width-1:0] r_keep;
    logic [CW-1:0] pkt_cnt;
    logic [IW-1:0] idle_cnt;

    logic          load;
    logic          xfer;
    logic          idle_tick;
    logic          idle_expire;
    logic [CW-1:0] next_idx;

    assign m_axis_tdata  = r_data;
    assign m_axis_tkeep  = r_keep;
    assign m_axis_tlast  = r_flush;
    // A non-final beat leaves only once its successor is present, so its tlast is settled.
    assign m_axis_tvalid = r_valid & (r_flush | s_axis_tvalid);
    assign s_axis_tready = ready_en & (~r_valid | m_axis_tready);

    assign load = s_axis_tvalid & s_axis_tready;
    assign xfer = m_axis_tvalid & m_axis_tready;

    // A beat arriving on the edge a closed packet leaves starts the next packet.
    assign next_idx = (xfer & r_flush) ? IDX_ONE : pkt_cnt + IDX_ONE;

    // Only true idle counts: back-pressured cycles have s_axis_tvalid high.
    assign idle_tick   = TO_EN & r_valid & ~r_flush & ~s_axis_tvalid;
    assign idle_expire = idle_tick & (idle_cnt == IDLE_LIM);

    // Hold register, packet/idle counters and HOLD/FLUSH flags.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            ready_en <= 1'b0;
            r_valid  <= 1'b0;
            r_flush  <= 1'b0;
            r_data   <= '0;
            r_keep   <= '0;
            pkt_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            ready_en <= 1'b1;
            if (load) begin
                // Arrival wins over a coincident timer expiry: the old beat leaves unflagged.
                r_valid  <= 1'b1;
                r_data   <= s_axis_tdata;
                r_keep   <= s_axis_tkeep;
                pkt_cnt  <= next_idx;
                r_flush  <= (next_idx == LEN_LIM) | (s_axis_tkeep != KEEP_ALL);
                idle_cnt <= '0;
            end else if (xfer) begin
                r_valid  <= 1'b0;
                r_flush  <= 1'b0;
                idle_cnt <= '0;
                if (r_flush) begin
                    pkt_cnt <= '0;
                end
            end else if (idle_tick) begin
                if (idle_expire) begin
                    r_flush <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_tlast_timeout.sv
// Scoreboard bench for axis_tlast_timeout (bus_width=2, max_len=4, timeout=8).
module tb_axis_tlast_timeout;

    logic        aclk = 1'b0;
    logic        arstn;
    logic [15:0] s_tdata;
    logic [1:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] m_tdata;
    logic [1:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  keep;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cyc = 0;
    int   first_cyc = 0;

    axis_tlast_timeout #(
        .bus_width(2),
        .max_len  (4),
        .timeout  (8)
    ) dut (
        .aclk         (aclk),
        .arstn        (arstn),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pop an expectation for every accepted output beat.
    always @(negedge aclk) begin : monitor
        exp_t e;
        if (arstn === 1'b1 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat actual=%h required=none", m_tdata);
            end else begin
                e = sb.pop_front();
                check("out_data", 32'(m_tdata), 32'(e.data));
                check("out_keep", 32'(m_tkeep), 32'(e.keep));
                check("out_last", 32'(m_tlast), 32'(e.last));
            end
        end
    end

    task automatic send_beat(input logic [15:0] d, input logic [1:0] k,
                             input logic last, input bit push);
        bit acc = 1'b0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tvalid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge aclk);
            acc = s_tready;
            @(posedge aclk);
            #1;
        end
        s_tvalid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=not_accepted required=accepted data=%h", d);
        end else begin
            acc_cyc = cyc;
            if (push) sb.push_back('{data: d, keep: k, last: last});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin
        arstn    = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;

        // Reset state
        #12;
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tlast",  32'(m_tlast),  32'd0);
        check("rst_tdata",  32'(m_tdata),  32'd0);
        check("rst_tkeep",  32'(m_tkeep),  32'd0);
        check("rst_tready", 32'(s_tready), 32'd0);
        #11;
        arstn = 1'b1;
        #1;
        check("rel_tready_pre", 32'(s_tready), 32'd0);
        @(posedge aclk);
        #1;
        check("rel_tready_post", 32'(s_tready), 32'd1);

        // Continuous stream; packet closes at index 4, tail closed by timeout
        for (int i = 0; i < 6; i++)
            send_beat(16'(i), 2'b11, (i == 3 || i == 5), 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge aclk);
            #1;
            if (k == 7) check("to_early", 32'({m_tvalid, m_tlast}), 32'd0);
            if (k == 8) check("to_exact", 32'({m_tvalid, m_tlast}), 32'd3);
        end
        idle(3);

        // max_len=4: tlast on beats 4, 8 and 9 (timeout), no bubbles
        for (int i = 0; i < 9; i++) begin
            send_beat(16'h0010 + 16'(i), 2'b11, (i == 3 || i == 7 || i == 8), 1'b1);
            if (i == 0) first_cyc = acc_cyc;
        end
        check("no_bubble", 32'(acc_cyc - first_cyc), 32'd8);
        idle(12);

        // Partial beat closes immediately; next packet restarts at index 1
        send_beat(16'h2021, 2'b11, 1'b0, 1'b1);
        send_beat(16'h2223, 2'b11, 1'b0, 1'b1);
        send_beat(16'h0024, 2'b01, 1'b1, 1'b1);
        check("partial_imm", 32'({m_tvalid, m_tlast}), 32'd3);
        send_beat(16'h2526, 2'b11, 1'b0, 1'b1);
        send_beat(16'h2728, 2'b11, 1'b0, 1'b1);
        send_beat(16'h292a, 2'b11, 1'b0, 1'b1);
        send_beat(16'h2b2c, 2'b11, 1'b1, 1'b1);
        idle(3);

        // Back-pressure: held beat stable, no tlast, input stalled
        m_tready = 1'b0;
        send_beat(16'h3031, 2'b11, 1'b0, 1'b1);
        s_tdata  = 16'h3233;
        s_tkeep  = 2'b11;
        s_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge aclk);
            #1;
            check("bp_hold", 32'({m_tvalid, m_tlast, s_tready, m_tdata}), {13'd0, 3'b100, 16'h3031});
        end
        m_tready = 1'b1;
        send_beat(16'h3233, 2'b11, 1'b1, 1'b1);
        idle(12);

        // Arrival on the expiry cycle: old beat leaves without tlast
        send_beat(16'h4041, 2'b11, 1'b0, 1'b1);
        idle(7);
        check("pre_expiry_last", 32'(m_tlast), 32'd0);
        send_beat(16'h4243, 2'b11, 1'b1, 1'b1);
        idle(12);

        // Reset mid-packet: held beat discarded, counters restart
        send_beat(16'h5051, 2'b11, 1'b0, 1'b1);
        send_beat(16'h5253, 2'b11, 1'b0, 1'b0);
        #3;
        arstn = 1'b0;
        #1;
        check("mid_rst_outs", 32'({m_tvalid, m_tlast, s_tready, m_tkeep, m_tdata}), 32'd0);
        @(posedge aclk);
        #4;
        arstn = 1'b1;
        #1;
        check("mid_rel_pre", 32'(s_tready), 32'd0);
        @(posedge aclk);
        #1;
        check("mid_rel_post", 32'(s_tready), 32'd1);
        send_beat(16'h6061, 2'b11, 1'b0, 1'b1);
        send_beat(16'h6263, 2'b11, 1'b0, 1'b1);
        send_beat(16'h6465, 2'b11, 1'b0, 1'b1);
        send_beat(16'h6667, 2'b11, 1'b1, 1'b1);
        idle(4);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
